// File: rtl/pdm_duty_ctrl.sv
// pdm_duty_ctrl: sequencer that owns the PDM modulator duty word.
// Buffers samples, slew-limits changes, and handles soft-start, mute and shutdown.
module pdm_duty_ctrl #(
  parameter int          DIV  = 1024,
  parameter logic [15:0] STEP = 16'h0100,
  parameter logic [15:0] MID  = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mute,
  input  logic [15:0] smpl,
  input  logic        smpl_vld,
  output logic        smpl_rdy,
  output logic [15:0] duty,
  output logic        upd_tick,
  output logic        underrun,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    SOFT = 2'b01,
    RUN  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam logic [15:0] CMAX = 16'(DIV - 1);

  state_t      st_q;
  logic [15:0] pre_q;
  logic [15:0] duty_q;
  logic [15:0] tgt_q;
  logic [15:0] buf_q [2];
  logic        wp_q;
  logic        rp_q;
  logic [1:0]  fcnt_q;

  logic        tick;
  logic        stop_req;
  logic        push;
  logic        pop;
  logic        flush;
  logic [15:0] head;
  logic [15:0] aim;
  logic [15:0] nd;

  // Move d toward t by at most STEP, never overshooting or wrapping.
  function automatic logic [15:0] step_fn(
    input logic [15:0] d,
    input logic [15:0] t
  );
    logic [16:0] s;
    step_fn = d;
    if (t > d) begin
      s = {1'b0, d} + {1'b0, STEP};
      step_fn = (s > {1'b0, t}) ? t : s[15:0];
    end else if (t < d) begin
      s = {1'b0, d} - {1'b0, STEP};
      step_fn = (s[16] || (s[15:0] < t)) ? t : s[15:0];
    end
  endfunction

  assign tick     = (st_q != OFF) && (pre_q == CMAX);
  assign stop_req = !en || mute;
  assign smpl_rdy = (st_q == RUN) && (fcnt_q < 2'd2);
  assign push     = smpl_vld && smpl_rdy;
  assign pop      = (st_q == RUN) && tick && (fcnt_q != 2'd0);
  assign flush    = (st_q == RUN) && stop_req;
  assign head     = buf_q[rp_q];
  assign underrun = (st_q == RUN) && tick && (fcnt_q == 2'd0);
  assign upd_tick = tick;
  assign duty     = duty_q;
  assign state    = st_q;

  // Ramp target for the current state and the stepped duty it yields.
  always_comb begin
    aim = duty_q;
    unique case (st_q)
      SOFT:    aim = MID;
      RUN:     aim = (fcnt_q != 2'd0) ? head : tgt_q;
      STOP:    aim = 16'h0000;
      default: aim = duty_q;
    endcase
    nd = step_fn(duty_q, aim);
  end

  // Update prescaler: free-running while active, parked at 0 in OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (st_q == OFF || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

  // Two-entry sample FIFO; emptied whenever RUN is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      fcnt_q   <= '0;
    end else if (flush) begin
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        buf_q[wp_q] <= smpl;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      if (push && !pop) begin
        fcnt_q <= fcnt_q + 2'd1;
      end else if (pop && !push) begin
        fcnt_q <= fcnt_q - 2'd1;
      end
    end
  end

  // Sequencer: state, duty and held target, stepping on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= OFF;
      duty_q <= '0;
      tgt_q  <= MID;
    end else begin
      unique case (st_q)
        OFF: begin
          duty_q <= '0;
          if (en && !mute) st_q <= SOFT;
        end
        SOFT: begin
          if (tick) duty_q <= nd;
          if (stop_req) begin
            st_q <= STOP;
          end else if (tick && nd == MID) begin
            st_q  <= RUN;
            tgt_q <= MID;
          end
        end
        RUN: begin
          if (tick) duty_q <= nd;
          if (pop) tgt_q <= head;
          if (stop_req) st_q <= STOP;
        end
        STOP: begin
          if (tick) begin
            duty_q <= nd;
            if (duty_q == 16'h0000) begin
              if (!en) st_q <= OFF;
              else if (!mute) st_q <= SOFT;
            end
          end
        end
        default: st_q <= OFF;
      endcase
    end
  end

endmodule
